// File: rtl/shift_ring_counter.sv
// Parametrised ring / Johnson shift counter with load, self-correction and position decode.
// Latency: q and wrap update one cycle after the edge; pos and illegal are combinational from q and mode.
// Backpressure: none; en gates shifting and q holds whenever en and load are low.
module shift_ring_counter #(
  parameter int WIDTH = 4,
  parameter int POSW  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [POSW-1:0]  pos,
  output logic             wrap,
  output logic             illegal
);

  // Johnson states are runs of ones anchored at bit 0 (2^k-1) or their complements.
  function automatic logic [WIDTH-1:0] low_mask(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= 0) return '0;
    return ones >> (WIDTH - k);
  endfunction

  logic [WIDTH-1:0] start_state;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ring_ok;
  logic             john_ok;
  logic [POSW-1:0]  ring_pos;
  logic [POSW-1:0]  john_pos;

  assign start_state = mode ? '0 : WIDTH'(1);

  // Ring legality and position: exactly one bit set, pos is its index.
  always_comb begin
    int cnt;
    cnt      = 0;
    ring_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        cnt      = cnt + 1;
        ring_pos = POSW'(i);
      end
    end
    ring_ok = (cnt == 1);
    if (!ring_ok) ring_pos = '0;
  end

  // Johnson legality and position: filling phase gives k, draining phase gives WIDTH+k.
  always_comb begin
    john_ok  = 1'b0;
    john_pos = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (q == low_mask(k)) begin
        john_ok  = 1'b1;
        john_pos = POSW'(k);
      end
    end
    for (int k = 1; k < WIDTH; k++) begin
      if (q == ~low_mask(k)) begin
        john_ok  = 1'b1;
        john_pos = POSW'(WIDTH + k);
      end
    end
  end

  assign illegal = mode ? !john_ok : !ring_ok;
  assign pos     = illegal ? '0 : (mode ? john_pos : ring_pos);

  // One shift step in the selected direction; Johnson feeds back the inverted end bit.
  always_comb begin
    shifted = q;
    if (!dir) shifted = {q[WIDTH-2:0], mode ? ~q[WIDTH-1] : q[WIDTH-1]};
    else      shifted = {mode ? ~q[0] : q[0], q[WIDTH-1:1]};
  end

  // Next-state selection: clear > load > correction > shift > hold; wrap only for shift steps.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (clear) begin
      q_next = start_state;
    end else if (load) begin
      q_next = load_val;
    end else if (en && illegal) begin
      q_next = start_state;
    end else if (en) begin
      q_next    = shifted;
      wrap_next = (shifted == start_state);
    end
  end

  // State and wrap registers.
  always_ff @(posedge clk) begin
    q    <= q_next;
    wrap <= wrap_next;
  end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Directed bench for shift_ring_counter at WIDTH=4.
// Checks sampled 1 time unit after each rising edge against hand-computed vectors.
// Inputs change only right after sampling, well clear of the next edge.
module tb_shift_ring_counter;

  logic       clk = 1'b0;
  logic       clear, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] pos;
  logic       wrap, illegal;

  int total = 0;
  int bad   = 0;

  shift_ring_counter #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .q(q), .pos(pos), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [2:0] ep,
                         input logic ew, input logic ei);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".pos"}, 32'(pos), 32'(ep));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ei));
  endtask

  logic [3:0] ring_q   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] ring_p   [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
  logic [3:0] john_q   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [2:0] john_p   [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    clear = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;

    // Ring reset and four left steps
    step();
    chk_all("ring_reset", 4'b0001, 3'd0, 1'b0, 1'b0);
    clear = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("ring_left%0d", i), ring_q[i], ring_p[i], i == 3, 1'b0);
    end

    // Johnson reset and eight left steps
    mode = 1'b1; clear = 1'b1; en = 1'b0;
    step();
    chk_all("john_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    clear = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("john_left%0d", i), john_q[i], john_p[i], i == 7, 1'b0);
    end

    // Ring right from start state
    mode = 1'b0; clear = 1'b1; en = 1'b0;
    step();
    chk("ring_r_reset.q", 32'(q), 32'h1);
    clear = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    chk_all("ring_right0", 4'b1000, 3'd3, 1'b0, 1'b0);
    step();
    chk_all("ring_right1", 4'b0100, 3'd2, 1'b0, 1'b0);

    // Ring right wrap onto 0001
    en = 1'b0; load = 1'b1; load_val = 4'b0010;
    step();
    chk("ring_r_load.q", 32'(q), 32'h2);
    load = 1'b0; en = 1'b1;
    step();
    chk_all("ring_right_wrap", 4'b0001, 3'd0, 1'b1, 1'b0);

    // Johnson right single step
    mode = 1'b1; clear = 1'b1; en = 1'b0;
    step();
    clear = 1'b0; en = 1'b1; dir = 1'b1;
    step();
    chk_all("john_right0", 4'b1000, 3'd7, 1'b0, 1'b0);

    // Illegal load, hold, then correction
    mode = 1'b0; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'b0110;
    step();
    chk_all("illegal_load", 4'b0110, 3'd0, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("illegal_hold%0d.q", i), 32'(q), 32'h6);
    end
    en = 1'b1;
    step();
    chk_all("correct", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Mode switch: Johnson 0111 becomes illegal as ring
    mode = 1'b1; clear = 1'b1; en = 1'b0;
    step();
    clear = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_all("msw_john", 4'b0111, 3'd3, 1'b0, 1'b0);
    en = 1'b0; mode = 1'b0;
    #1;
    chk("msw_illegal_now", 32'(illegal), 32'h1);
    chk("msw_pos_now", 32'(pos), 32'h0);
    step();
    chk("msw_held.q", 32'(q), 32'h7);
    en = 1'b1;
    step();
    chk_all("msw_corrected", 4'b0001, 3'd0, 1'b0, 1'b0);
    en = 1'b0; mode = 1'b1;
    #1;
    chk("msw_back_illegal", 32'(illegal), 32'h0);
    chk("msw_back_pos", 32'(pos), 32'h1);

    // Priority: clear over load and en, then load over shift
    mode = 1'b0; load = 1'b1; load_val = 4'b0100;
    step();
    chk("prio_pre.q", 32'(q), 32'h4);
    clear = 1'b1; load = 1'b1; load_val = 4'b1000; en = 1'b1;
    step();
    chk_all("prio_clear", 4'b0001, 3'd0, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    chk_all("prio_load", 4'b1000, 3'd3, 1'b0, 1'b0);
    load = 1'b0;
    step();
    chk_all("prio_after_load_shift", 4'b0001, 3'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_ring_counter.md
Name: shift_ring_counter

Overview:
- Parametrised ring / Johnson (twisted-ring) shift counter. Successor to the fixed 4-bit ring counter.
- Adds runtime mode select, shift direction, count enable, parallel load, illegal-state detection with self-correction, and a decoded position output.
- Used as a one-hot sequencer / phase generator in lab datapaths and for driving scanned displays.

Parameters:
- WIDTH, 4: number of flip-flops; legal range 2..16.
- POSW, derived as clog2(2*WIDTH): width of pos output; 3 for WIDTH=4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clear  input  1  synchronous active-high reset.
- en  input  1  shift enable; q holds when low.
- mode  input  1  0 = ring, 1 = Johnson.
- dir  input  1  0 = shift left (toward MSB), 1 = shift right.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  counter state, registered.
- pos  output  POSW  step index of q, combinational from q and mode.
- wrap  output  1  registered one-cycle pulse when a shift lands on the start state.
- illegal  output  1  combinational; q is not a legal state for the current mode.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (clear).
- Priority per rising edge: clear > load > correction > shift > hold.
- clear:
  - q <= start state of the current mode: ring = 0...01; Johnson = all zeros.
  - wrap <= 0.
  - mode is sampled in the same cycle as clear.
- load=1 (clear=0): q <= load_val unconditionally, even if illegal; wrap <= 0.
- Correction: if en=1 and illegal=1, q <= start state of the current mode instead of shifting; wrap <= 0.
- Shift (en=1, legal q):
  - Ring left: q <= {q[W-2:0], q[W-1]}.
  - Ring right: q <= {q[0], q[W-1:1]}.
  - Johnson left: q <= {q[W-2:0], ~q[W-1]}.
  - Johnson right: q <= {~q[0], q[W-1:1]}.
- Hold: en=0 and load=0 leaves q unchanged, even if q is illegal. wrap <= 0.
- Latency: q reflects any action one cycle after the edge. No pipelining.
- Legality:
  - Ring: exactly one bit set.
  - Johnson: q = 2^k-1 for k=0..W, or q = ~(2^k-1) for k=1..W-1. That gives 2W states.
- pos:
  - Ring: index of the set bit, 0..W-1.
  - Johnson: k when q = 2^k-1 (k=0..W); W+k when q = ~(2^k-1).
  - Illegal q: pos = 0.
  - pos never exceeds 2W-1.
- wrap:
  - Set to 1 on the edge where a shift step (not clear/load/correction) writes the start state.
  - Cleared on any other edge. This applies in both directions.
- Mode change: takes effect immediately for illegal/pos evaluation. Does not alter q by itself.
  - If q is illegal under the new mode, the next enabled edge corrects it.
  - A mode change with en=0 leaves q illegal and held.
- Reset mid-operation: clear overrides load/en in the same cycle.
- Outputs after clear, mode=0: q=0001, pos=0, wrap=0, illegal=0.
- Outputs after clear, mode=1: q=0000, pos=0, wrap=0, illegal=0.
- No other state besides q and the wrap register.

Test Plan:
- WIDTH=4, mode=0, dir=0: clear for 1 cycle, then en=1 for 4 cycles. Required:
  - q = 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - pos = 0,1,2,3,0.
  - wrap=1 only in the cycle q returns to 0001.
- mode=1, dir=0: clear, then en=1 for 8 cycles. Required:
  - q = 0001,0011,0111,1111,1110,1100,1000,0000.
  - pos = 1..7,0.
  - wrap=1 only on the 0000 cycle.
- mode=0, dir=1 from 0001: en for 2 cycles. Required: q = 1000 (pos=3), then 0100 (pos=2). mode=1, dir=1 from 0000: one step gives q=1000, pos=7.
- Illegal load and correction:
  - mode=0, load=1, load_val=0110: q=0110, illegal=1, pos=0.
  - en=0 for 3 cycles: q holds 0110.
  - Next en=1: q=0001, illegal=0, wrap=0.
- Mode switch: mode=1 with q=0111, switch mode to 0. Required:
  - illegal=1 in the same cycle.
  - Next en edge: q=0001.
  - Switching back to mode=1 with q=0001: legal, pos=1.
- Priority: from q=0100 (ring), assert clear=1, load=1 (load_val=1000), en=1 together. Required: q=0001, wrap=0. Then load=1 with en=1: q=load_val exactly, no shift applied that cycle.
